// File: rtl/demux_deser8_pkg.sv
// Shared constants and index mapping for the serial-to-parallel receive path.
package demux_deser8_pkg;
    localparam int                 DESER_W     = 8;
    localparam int                 DESER_IDX_W = 3;
    localparam logic [DESER_W-1:0] RESET_WORD  = 8'h00;

    // Bit-order mapping from arrival index to word position.
    function automatic logic [DESER_IDX_W-1:0] map_idx(
        input logic [DESER_IDX_W-1:0] idx,
        input bit                     lsb_first
    );
        return lsb_first ? idx : (DESER_IDX_W'(DESER_W - 1) - idx);
    endfunction
endpackage

// File: rtl/demux1x8.sv
// 1-to-8 demultiplexer: one-hot write enables plus the steered data bit.
module demux1x8
    import demux_deser8_pkg::*;
(
    input  logic                   d,
    input  logic                   en,
    input  logic [DESER_IDX_W-1:0] sel,
    output logic [DESER_W-1:0]     en_vec,
    output logic [DESER_W-1:0]     d_vec
);
    assign en_vec = {{(DESER_W-1){1'b0}}, en} << sel;
    assign d_vec  = en_vec & {DESER_W{d}};
endmodule

// File: rtl/demux_deser8.sv
// Serial-to-parallel deserialiser: demuxes bits into an assembly register and
// presents each completed byte on a one-entry valid/ready buffer.
module demux_deser8
    import demux_deser8_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din,
    input  logic                   din_valid,
    input  logic                   frame_start,
    output logic [DESER_W-1:0]     dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [DESER_IDX_W-1:0] bit_idx,
    output logic                   overflow
);
    logic [DESER_W-1:0]     r_asm;
    logic [DESER_W-1:0]     r_dout;
    logic                   r_dout_valid;
    logic [DESER_IDX_W-1:0] r_bit_idx;
    logic                   r_overflow;

    logic [DESER_IDX_W-1:0] w_idx_eff;
    logic [DESER_IDX_W-1:0] w_pos;
    logic [DESER_W-1:0]     w_en_vec;
    logic [DESER_W-1:0]     w_d_vec;
    logic [DESER_W-1:0]     w_asm_nxt;
    logic                   w_complete;
    logic                   w_buf_free;
    logic                   w_xfer;
    logic [DESER_IDX_W-1:0] w_idx_nxt;
    logic [DESER_W-1:0]     w_dout_nxt;
    logic                   w_dout_valid_nxt;
    logic                   w_overflow_nxt;

    // frame_start forces the incoming bit (if any) to index 0.
    assign w_idx_eff = frame_start ? '0 : r_bit_idx;
    assign w_pos     = map_idx(w_idx_eff, LSB_FIRST);

    demux1x8 u_demux (
        .d      (din),
        .en     (din_valid),
        .sel    (w_pos),
        .en_vec (w_en_vec),
        .d_vec  (w_d_vec)
    );

    // The merged value doubles as the same-cycle bypass for the completed word.
    assign w_asm_nxt  = (r_asm & ~w_en_vec) | w_d_vec;
    assign w_complete = din_valid && !frame_start && (r_bit_idx == DESER_IDX_W'(DESER_W - 1));
    assign w_xfer     = r_dout_valid && dout_ready;
    assign w_buf_free = !r_dout_valid || dout_ready;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_idx_nxt        = r_bit_idx;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = r_dout_valid;
        w_overflow_nxt   = r_overflow;

        if (din_valid) begin
            w_idx_nxt = w_idx_eff + DESER_IDX_W'(1);
        end else if (frame_start) begin
            w_idx_nxt = '0;
        end

        if (w_complete) begin
            if (w_buf_free) begin
                w_dout_nxt       = w_asm_nxt;
                w_dout_valid_nxt = 1'b1;
            end else begin
                w_overflow_nxt = 1'b1;
            end
        end else if (w_xfer) begin
            w_dout_valid_nxt = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm        <= RESET_WORD;
            r_dout       <= RESET_WORD;
            r_dout_valid <= 1'b0;
            r_bit_idx    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_asm        <= w_asm_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_bit_idx    <= w_idx_nxt;
            r_overflow   <= w_overflow_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign bit_idx    = r_bit_idx;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_demux_deser8.sv
// Self-checking bench: one LSB-first and one MSB-first instance share stimulus;
// expected words are queued when sent and compared when the DUT hands them over.
module tb_demux_deser8;
    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       frame_start;
    logic       dout_ready;

    logic [7:0] lsb_dout,  msb_dout;
    logic       lsb_valid, msb_valid;
    logic [2:0] lsb_idx,   msb_idx;
    logic       lsb_ovf,   msb_ovf;

    int n_checks   = 0;
    int n_failures = 0;

    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    always #5 clk = ~clk;

    demux_deser8 #(.LSB_FIRST(1'b1)) u_lsb (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .dout        (lsb_dout),
        .dout_valid  (lsb_valid),
        .dout_ready  (dout_ready),
        .bit_idx     (lsb_idx),
        .overflow    (lsb_ovf)
    );

    demux_deser8 #(.LSB_FIRST(1'b0)) u_msb (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .dout        (msb_dout),
        .dout_valid  (msb_valid),
        .dout_ready  (dout_ready),
        .bit_idx     (msb_idx),
        .overflow    (msb_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every word the consumer accepts against the queue.
    always @(negedge clk) begin
        if (!rst && lsb_valid && dout_ready) begin
            if (q_lsb.size() == 0) check("lsb_unexpected_word", {24'h0, lsb_dout}, 32'hffff_ffff);
            else                   check("lsb_word", {24'h0, lsb_dout}, {24'h0, q_lsb.pop_front()});
        end
        if (!rst && msb_valid && dout_ready) begin
            if (q_msb.size() == 0) check("msb_unexpected_word", {24'h0, msb_dout}, 32'hffff_ffff);
            else                   check("msb_word", {24'h0, msb_dout}, {24'h0, q_msb.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic fs);
        din_valid   = v;
        din         = b;
        frame_start = fs;
        step();
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int k = 0; k < 8; k++) drive(1'b1, w[k], 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_lsb_dout"},  {24'h0, lsb_dout}, 32'h0);
        check({tag, "_lsb_valid"}, {31'h0, lsb_valid}, 32'h0);
        check({tag, "_lsb_idx"},   {29'h0, lsb_idx}, 32'h0);
        check({tag, "_lsb_ovf"},   {31'h0, lsb_ovf}, 32'h0);
        check({tag, "_msb_valid"}, {31'h0, msb_valid}, 32'h0);
        check({tag, "_msb_idx"},   {29'h0, msb_idx}, 32'h0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{word: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5};
        vecs[1] = '{word: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80};
        vecs[2] = '{word: 8'h3C, exp_lsb: 8'h3C, exp_msb: 8'h3C};
        vecs[3] = '{word: 8'h96, exp_lsb: 8'h96, exp_msb: 8'h69};
        vecs[4] = '{word: 8'hF0, exp_lsb: 8'hF0, exp_msb: 8'h0F};

        din = 1'b0; din_valid = 1'b0; frame_start = 1'b0; dout_ready = 1'b1;
        do_reset();
        check_zero("reset");

        // Table-driven words, consumer always ready: one-cycle valid pulse each.
        foreach (vecs[i]) begin
            q_lsb.push_back(vecs[i].exp_lsb);
            q_msb.push_back(vecs[i].exp_msb);
            send_word(vecs[i].word);
            check("tbl_lsb_dout",  {24'h0, lsb_dout}, {24'h0, vecs[i].exp_lsb});
            check("tbl_msb_dout",  {24'h0, msb_dout}, {24'h0, vecs[i].exp_msb});
            check("tbl_lsb_valid", {31'h0, lsb_valid}, 32'h1);
            check("tbl_lsb_idx",   {29'h0, lsb_idx}, 32'h0);
            step();
            check("tbl_valid_drop", {31'h0, lsb_valid}, 32'h0);
            check("tbl_dout_hold",  {24'h0, lsb_dout}, {24'h0, vecs[i].exp_lsb});
        end

        // Gaps between valid bits: index holds, same word results.
        q_lsb.push_back(8'hA5);
        q_msb.push_back(8'hA5);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] w;
            w = 8'hA5;
            drive(1'b1, w[k], 1'b0);
            if (k < 7) begin
                drive(1'b0, 1'b1, 1'b0);
                check("gap_idx_hold", {29'h0, lsb_idx}, k + 1);
                check("gap_no_word",  {31'h0, lsb_valid}, 32'h0);
            end
        end
        check("gap_dout", {24'h0, lsb_dout}, 32'hA5);
        step();

        // Consumer stalled: second word dropped, overflow sticky, single transfer.
        dout_ready = 1'b0;
        q_lsb.push_back(8'h3C);
        q_msb.push_back(8'h3C);
        send_word(8'h3C);
        check("stall_ovf_clear", {31'h0, lsb_ovf}, 32'h0);
        send_word(8'hC3);
        check("stall_dout_stable", {24'h0, lsb_dout}, 32'h3C);
        check("stall_valid",       {31'h0, lsb_valid}, 32'h1);
        check("stall_lsb_ovf",     {31'h0, lsb_ovf}, 32'h1);
        check("stall_msb_ovf",     {31'h0, msb_ovf}, 32'h1);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check("stall_single_xfer", {31'h0, lsb_valid}, 32'h0);
        check("stall_ovf_sticky",  {31'h0, lsb_ovf}, 32'h1);
        step();
        check("stall_no_second",   {31'h0, lsb_valid}, 32'h0);

        do_reset();
        check_zero("reset2");

        // Back-to-back: ready asserted with the next word's 8th bit.
        dout_ready = 1'b0;
        q_lsb.push_back(8'h3C);
        q_msb.push_back(8'h3C);
        send_word(8'h3C);
        q_lsb.push_back(8'hC3);
        q_msb.push_back(8'hC3);
        for (int k = 0; k < 7; k++) begin
            logic [7:0] w;
            w = 8'hC3;
            drive(1'b1, w[k], 1'b0);
            check("b2b_hold_valid", {31'h0, lsb_valid}, 32'h1);
        end
        dout_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        check("b2b_dout",  {24'h0, lsb_dout}, 32'hC3);
        check("b2b_valid", {31'h0, lsb_valid}, 32'h1);
        check("b2b_ovf",   {31'h0, lsb_ovf}, 32'h0);
        step();
        check("b2b_drain", {31'h0, lsb_valid}, 32'h0);

        // frame_start mid-word: 5 bits discarded, restart with din=1 at index 0.
        q_lsb.push_back(8'h6B);
        q_msb.push_back(8'hD6);
        for (int k = 0; k < 5; k++) drive(1'b1, k[0], 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        check("fs_idx",      {29'h0, lsb_idx}, 32'h1);
        check("fs_no_word",  {31'h0, lsb_valid}, 32'h0);
        for (int k = 1; k < 8; k++) begin
            logic [7:0] w;
            w = 8'h6B;
            drive(1'b1, w[k], 1'b0);
        end
        check("fs_lsb_dout", {24'h0, lsb_dout}, 32'h6B);
        check("fs_msb_dout", {24'h0, msb_dout}, 32'hD6);
        step();

        // frame_start at index 7 never completes a word; idle frame_start zeroes index.
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 1'b0);
        check("fs7_idx_pre", {29'h0, lsb_idx}, 32'h7);
        drive(1'b1, 1'b0, 1'b1);
        check("fs7_no_word", {31'h0, lsb_valid}, 32'h0);
        check("fs7_idx",     {29'h0, lsb_idx}, 32'h1);
        drive(1'b0, 1'b0, 1'b1);
        check("fs_idle_idx", {29'h0, lsb_idx}, 32'h0);

        // Reset mid-word overrides a valid bit and clears everything.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0);
        check("rst_mid_idx_pre", {29'h0, lsb_idx}, 32'h3);
        din_valid = 1'b1;
        din       = 1'b1;
        do_reset();
        din_valid = 1'b0;
        check_zero("rst_mid");

        step();
        check("lsb_queue_empty", q_lsb.size(), 32'h0);
        check("msb_queue_empty", q_msb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end
endmodule

// File: doc/demux_deser8.md
Name: demux_deser8

Overview:
- Receive-side counterpart to the 8:1 selection path.
- Accepts one serial bit per valid cycle and steers it through a 1-to-8 demultiplexer into an 8-bit assembly register, indexed by a 3-bit bit counter.
- On the 8th bit, presents the completed word on a one-entry valid/ready output buffer.
- Sits between a serial link (driven by a counter-sequenced mux8x1 on the far end) and parallel consumers.

Parameters:
- LSB_FIRST, 1: 1 = k-th received bit lands in dout[k] (matches sel=k selecting in[k]); 0 = k-th bit lands in dout[7-k].

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit
- din_valid  input  1  din is sampled this cycle
- frame_start  input  1  resynchronise: discard partial word, restart at index 0
- dout  output  8  assembled word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout this cycle
- bit_idx  output  3  index the next valid bit will fill
- overflow  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (rst=1 at clock edge): bit_idx=0, assembly register=0, dout=8'h00, dout_valid=0, overflow=0. Reset overrides all other inputs, including mid-word; any partial word is discarded.
- Bit capture, when din_valid=1:
  - Demux enable for position p = map(bit_idx), where map is the identity for LSB_FIRST=1 and 7-idx for LSB_FIRST=0.
  - asm[p] <= din.
  - bit_idx <= bit_idx+1, wrapping 7->0 (3-bit natural wrap).
- din_valid=0: no change to the assembly register or bit_idx.
- Word completion: din_valid=1 with effective index 7.
  - Completed word = assembly register with position map(7) replaced by din (same-cycle bypass, no extra cycle).
  - Buffer free (dout_valid=0, or dout_valid=1 and dout_ready=1 this cycle): dout <= completed word, dout_valid <= 1 on the next edge.
  - Buffer full (dout_valid=1 and dout_ready=0): word dropped, dout unchanged, overflow <= 1.
- Latency: dout_valid rises on the clock edge that samples the 8th valid bit; it is visible in the following cycle.
- Output handshake:
  - Transfer occurs when dout_valid && dout_ready.
  - After a transfer with no same-cycle load, dout_valid <= 0 and dout keeps its value.
  - A transfer and a load in the same cycle give back-to-back words with dout_valid held at 1.
  - dout must stay stable while dout_valid=1 and dout_ready=0.
- Assembly register is not cleared between words; stale bits are always overwritten before the next completion.
- frame_start:
  - frame_start=1 with din_valid=0: bit_idx <= 0.
  - frame_start=1 with din_valid=1: din is treated as index 0 (asm[map(0)] <= din), bit_idx <= 1.
  - frame_start never produces a word, even if bit_idx was 7.
  - frame_start does not affect dout, dout_valid or overflow.
- overflow: set only by a dropped word; cleared only by rst.
- bit_idx is registered and reflects the state after the last edge.

Decomposition:
- Shared package: constants DESER_W=8, DESER_IDX_W=3, and the RESET_WORD constant 8'h00.
- One sub-module: demux1x8 (combinational; inputs d, en, sel[2:0]; output one-hot en_vec[7:0] = en << sel). It generates the per-bit write enables for the assembly register.
- Counter, completion detect, output buffer and overflow logic live in the top module.

Test Plan:
1. Reset, then LSB_FIRST=1, dout_ready=1, feed bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles -> dout=8'hA5 with dout_valid=1 for exactly one cycle after the 8th bit; bit_idx back to 0.
2. LSB_FIRST=0, same bit stream -> dout=8'hA5 bit-reversed = 8'hA5 (palindrome check: use stream for 8'h01, expect 8'h80 instead).
3. Gaps: the same 8 bits with din_valid deasserted on alternate cycles -> identical dout; bit_idx holds during gaps.
4. dout_ready=0, send two full words (8'h3C, then 8'hC3) -> dout stays 8'h3C with dout_valid=1; overflow=1 after the 8th bit of word 2; asserting dout_ready then yields a single transfer.
5. Back-to-back: dout_ready asserted in the same cycle as the next word's 8th bit -> dout changes 8'h3C->8'hC3 with dout_valid continuously 1, overflow=0.
6. Send 5 bits, then frame_start with din_valid=1, din=1, then 7 more bits -> word is 1 followed by the 7 new bits, no partial word emitted. Separately, rst asserted after 3 bits -> all outputs return to 0 and bit_idx=0.
